// File: rtl/level_meter.sv
// level_meter: frame-based audio level / peak-hold meter.
// Each frame snapshots a 16-sample window, computes its mean, then the mean
// absolute deviation, and maps that to a 0..15 bar level with a slowly
// decaying peak-hold.
// Handshake: level_valid is a one-cycle pulse; level and peak are valid in
// that cycle and hold until the next pulse. There is no back-pressure.
module level_meter #(
  parameter int unsigned FRAME_TICKS  = 16,
  parameter int unsigned DECAY_FRAMES = 8
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        clk_sampling,
  input  logic [17:0] samples [0:15],
  output logic [3:0]  level,
  output logic [3:0]  peak,
  output logic        level_valid,
  output logic        busy,
  output logic        overrun,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUM  = 3'd1,
    S_MEAN = 3'd2,
    S_DEV  = 3'd3,
    S_MAP  = 3'd4
  } state_t;

  localparam logic [15:0] LAST_TICK  = 16'(FRAME_TICKS - 1);
  localparam logic [7:0]  DECAY_LAST = 8'(DECAY_FRAMES);

  state_t      state_q, state_d;
  logic [2:0]  sync_q;
  logic [15:0] tick_cnt_q;
  logic [17:0] buf_q [0:15];
  logic [3:0]  idx_q;
  logic [21:0] sum_q;
  logic [21:0] devsum_q;
  logic [17:0] mean_q;
  logic [7:0]  decay_q, decay_d;
  logic [3:0]  level_q, peak_q, peak_d, level_next;
  logic        valid_q, overrun_q;
  logic        tick, frame_start, accept;
  logic [17:0] cur, absdiff;

  // Rising edge of the synchronised strobe; a frame starts when the tick wraps the counter.
  assign tick        = sync_q[1] & ~sync_q[2];
  assign frame_start = tick && (tick_cnt_q == LAST_TICK);
  assign accept      = frame_start && (state_q == S_IDLE);

  assign cur     = buf_q[idx_q];
  // Subtract the smaller from the larger so the 18-bit difference never wraps.
  assign absdiff = (cur >= mean_q) ? (cur - mean_q) : (mean_q - cur);

  // avg = devsum[21:4]; anything at or above 0x10000 saturates the bar.
  assign level_next = (devsum_q[21:20] != 2'b00) ? 4'd15 : devsum_q[19:16];

  assign level       = level_q;
  assign peak        = peak_q;
  assign level_valid = valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

  // Next-state logic: two 16-cycle passes separated by single-cycle MEAN and MAP steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SUM;
      S_SUM:   if (idx_q == 4'd15) state_d = S_MEAN;
      S_MEAN:  state_d = S_DEV;
      S_DEV:   if (idx_q == 4'd15) state_d = S_MAP;
      S_MAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Peak-hold: jump up immediately, otherwise step down one every DECAY_FRAMES frames.
  always_comb begin
    peak_d  = peak_q;
    decay_d = decay_q;
    if (level_next >= peak_q) begin
      peak_d  = level_next;
      decay_d = '0;
    end else if ((decay_q + 8'd1) == DECAY_LAST) begin
      decay_d = '0;
      peak_d  = ((peak_q - 4'd1) > level_next) ? (peak_q - 4'd1) : level_next;
    end else begin
      decay_d = decay_q + 8'd1;
    end
  end

  // State register.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Strobe synchroniser/edge detector and free-running frame tick counter.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], clk_sampling};
      if (tick) tick_cnt_q <= (tick_cnt_q == LAST_TICK) ? 16'd0 : tick_cnt_q + 16'd1;
    end
  end

  // Sample window snapshot, taken only when a frame start is accepted.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= samples[i];
    end
  end

  // Arithmetic datapath: sum, mean, deviation sum, sample index.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      sum_q    <= '0;
      mean_q   <= '0;
      devsum_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_q <= '0;
          if (accept) sum_q <= '0;
        end
        S_SUM: begin
          sum_q <= sum_q + {4'd0, cur};
          idx_q <= idx_q + 4'd1;
        end
        S_MEAN: begin
          mean_q   <= sum_q[21:4];
          devsum_q <= '0;
          idx_q    <= '0;
        end
        S_DEV: begin
          devsum_q <= devsum_q + {4'd0, absdiff};
          idx_q    <= idx_q + 4'd1;
        end
        default: idx_q <= '0;
      endcase
    end
  end

  // Output registers, updated on the edge that ends MAP; overrun is sticky until reset.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      level_q   <= '0;
      peak_q    <= '0;
      decay_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == S_MAP) begin
        level_q <= level_next;
        peak_q  <= peak_d;
        decay_q <= decay_d;
        valid_q <= 1'b1;
      end
      if (frame_start && (state_q != S_IDLE)) overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_level_meter.sv
// Directed testbench for level_meter. Two instances: A (FRAME_TICKS=1,
// DECAY_FRAMES=2) carries most scenarios; B (FRAME_TICKS=16, default decay)
// carries the multi-tick frame scenario.
module tb_level_meter;

  logic        clk;
  logic        reset;
  logic        samp_a, samp_b;
  logic [17:0] samples [0:15];

  logic [3:0]  level_a, peak_a, level_b, peak_b;
  logic        valid_a, busy_a, overrun_a, valid_b, busy_b, overrun_b;
  logic [2:0]  state_a, state_b;

  int errors = 0;
  int checks = 0;

  level_meter #(.FRAME_TICKS(1), .DECAY_FRAMES(2)) u_dut_a (
    .clk_25(clk), .reset(reset), .clk_sampling(samp_a), .samples(samples),
    .level(level_a), .peak(peak_a), .level_valid(valid_a), .busy(busy_a),
    .overrun(overrun_a), .dbg_state(state_a)
  );

  level_meter #(.FRAME_TICKS(16), .DECAY_FRAMES(8)) u_dut_b (
    .clk_25(clk), .reset(reset), .clk_sampling(samp_b), .samples(samples),
    .level(level_b), .peak(peak_b), .level_valid(valid_b), .busy(busy_b),
    .overrun(overrun_b), .dbg_state(state_b)
  );

  // 25 MHz clock
  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic set_samples(input logic [17:0] va, input logic [17:0] vb);
    for (int i = 0; i < 16; i++) samples[i] = (i % 2 == 0) ? va : vb;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    samp_a = 1'b0;
    samp_b = 1'b0;
    set_samples(18'h10000, 18'h10000);
    repeat (2) @(negedge clk);
    checks++; if (level_a !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_a); end
    checks++; if (peak_a !== 4'd0) begin errors++; $display("FAIL reset_peak: got %0d expected 0", peak_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_a); end
    checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_a); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0/0", busy_a, valid_a);
    end
  endtask

  // One strobe on A. Cycle c is the cycle following snapshot edge T+c-1, so
  // the result registered on the edge ending MAP (T+34) is seen in cycle 35.
  task automatic do_frame(input logic [17:0] va, input logic [17:0] vb,
                          input logic [3:0] exp_lvl, input logic [3:0] exp_pk,
                          input string tag);
    int vcount;
    int vcyc;
    logic [3:0] got_lvl, got_pk;
    set_samples(va, vb);
    vcount = 0; vcyc = -1; got_lvl = 'x; got_pk = 'x;
    @(negedge clk); samp_a = 1'b1;
    @(negedge clk);
    @(negedge clk); samp_a = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL %s_busy_start: got %b expected 1", tag, busy_a); end
      end
      if (valid_a === 1'b1) begin
        vcount++;
        if (vcyc < 0) begin vcyc = c; got_lvl = level_a; got_pk = peak_a; end
      end
      if (c == 40) begin
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b expected 0", tag, busy_a); end
      end
    end
    checks++; if (vcount != 1) begin errors++; $display("FAIL %s_valid_count: got %0d expected 1", tag, vcount); end
    checks++; if (vcyc != 35) begin errors++; $display("FAIL %s_valid_latency: got %0d expected 35", tag, vcyc); end
    checks++; if (got_lvl !== exp_lvl) begin errors++; $display("FAIL %s_level: got %0d expected %0d", tag, got_lvl, exp_lvl); end
    checks++; if (got_pk !== exp_pk) begin errors++; $display("FAIL %s_peak: got %0d expected %0d", tag, got_pk, exp_pk); end
  endtask

  task automatic test_flat();
    do_frame(18'h10000, 18'h10000, 4'd0, 4'd0, "flat");
  endtask

  task automatic test_alternating();
    // mean 0x12000, every deviation 0x2000 -> avg 0x2000 -> level 2
    do_frame(18'h10000, 18'h14000, 4'd2, 4'd2, "alt");
  endtask

  task automatic test_full_scale_decay();
    // mean 0x1FFE0, avg 0x1FFE0 -> saturates to 15
    do_frame(18'h00000, 18'h3FFC0, 4'd15, 4'd15, "full");
    do_frame(18'h10000, 18'h10000, 4'd0, 4'd15, "decay1");
    do_frame(18'h10000, 18'h10000, 4'd0, 4'd14, "decay2");
    do_frame(18'h10000, 18'h10000, 4'd0, 4'd14, "decay3");
    do_frame(18'h10000, 18'h10000, 4'd0, 4'd13, "decay4");
  endtask

  // Strobes every 20 cycles: starts at T, T+40 accepted; T+20, T+60 dropped.
  task automatic test_overrun();
    int vcount;
    int v1, v2;
    set_samples(18'h10000, 18'h14000);
    vcount = 0; v1 = -1; v2 = -1;
    for (int n = 0; n < 130; n++) begin
      @(negedge clk);
      if (n == 22) begin
        checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b expected 0", overrun_a); end
      end
      if (n == 23) begin
        checks++; if (overrun_a !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun_a); end
      end
      if (valid_a === 1'b1) begin
        vcount++;
        if (v1 < 0) v1 = n; else v2 = n;
        checks++; if (level_a !== 4'd2) begin errors++; $display("FAIL ovr_level: got %0d expected 2", level_a); end
      end
      samp_a = (n % 20 == 0) && (n < 80);
    end
    checks++; if (vcount != 2) begin errors++; $display("FAIL ovr_valid_count: got %0d expected 2", vcount); end
    checks++; if (v1 != 37 || v2 != 77) begin errors++; $display("FAIL ovr_valid_pos: got %0d,%0d expected 37,77", v1, v2); end
    checks++; if (overrun_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun_a); end
    // peak 13 with decay counter 0 -> first frame counts, second steps to 12
    checks++; if (peak_a !== 4'd12) begin errors++; $display("FAIL ovr_peak: got %0d expected 12", peak_a); end
  endtask

  task automatic test_reset_mid_dev();
    int vcount;
    set_samples(18'h00000, 18'h3FFC0);
    @(negedge clk); samp_a = 1'b1;
    @(negedge clk);
    @(negedge clk); samp_a = 1'b0;
    repeat (21) @(negedge clk);
    checks++; if (state_a !== 3'd3 || busy_a !== 1'b1) begin
      errors++; $display("FAIL mid_dev_state: got state=%0d busy=%b expected 3/1", state_a, busy_a);
    end
    #5 reset = 1'b1;
    #1;
    checks++; if (level_a !== 4'd0 || peak_a !== 4'd0) begin
      errors++; $display("FAIL mid_dev_reset_lp: got level=%0d peak=%0d expected 0/0", level_a, peak_a);
    end
    checks++; if (busy_a !== 1'b0 || overrun_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL mid_dev_reset_flags: got busy=%b ovr=%b valid=%b expected 0/0/0", busy_a, overrun_a, valid_a);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_a === 1'b1) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL mid_dev_no_valid: got %0d expected 0", vcount); end
    do_frame(18'h10000, 18'h14000, 4'd2, 4'd2, "after_rst");
  endtask

  // 48 strobes at 100-cycle spacing on B: frame starts on ticks 16, 32, 48.
  task automatic test_frame_ticks16();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    set_samples(18'h10000, 18'h14000);
    exp_q = {32'd1537, 32'd3137, 32'd4737};
    for (int n = 0; n < 4900; n++) begin
      @(negedge clk);
      if (valid_b === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL ft16_extra_valid: got pulse at %0d expected none", n);
        end else begin
          e = exp_q.pop_front();
          if (32'(n) !== e) begin errors++; $display("FAIL ft16_valid_pos: got %0d expected %0d", n, e); end
        end
        checks++; if (level_b !== 4'd2) begin errors++; $display("FAIL ft16_level: got %0d expected 2", level_b); end
      end
      samp_b = (n % 100 == 0) && (n < 4800);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ft16_missing_valid: got %0d left expected 0", exp_q.size()); end
    checks++; if (overrun_b !== 1'b0) begin errors++; $display("FAIL ft16_overrun: got %b expected 0", overrun_b); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_alternating();
    test_full_scale_decay();
    test_overrun();
    test_reset_mid_dev();
    test_frame_ticks16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/level_meter.md
LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 Parameter FRAME_TICKS, default 16: number of clk_sampling rising edges per analysis frame (1..65535).
REQ-002 Parameter DECAY_FRAMES, default 8: number of frames between successive peak decrements (1..255).
REQ-003 Port clk_25  input  1: 25 MHz system clock; the only clock.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port clk_sampling  input  1: sample-rate strobe, produced in the clk_25 domain, treated as a level.
REQ-006 Port samples  input  18 x [0:15]: unsigned sample window; index 0 is newest; each value is a 12-bit ADC code shifted left 6.
REQ-007 Port level  output  4: average-deviation bar level, 0..15.
REQ-008 Port peak  output  4: peak-hold level, 0..15.
REQ-009 Port level_valid  output  1: one-cycle pulse when level and peak update.
REQ-010 Port busy  output  1: high whenever the FSM is not IDLE.
REQ-011 Port overrun  output  1: sticky flag, set when a frame start is dropped.

Function
REQ-012 clk_sampling SHALL pass through two flops; a tick is flagged when the second flop is 1 and a third delay flop is 0.
REQ-013 A tick counter SHALL count ticks modulo FRAME_TICKS; a frame start occurs on the tick that wraps the counter to 0.
REQ-014 On a frame start in IDLE, all 16 samples SHALL be copied into an internal buffer on the same edge (snapshot cycle T), and the FSM SHALL enter SUM.
REQ-015 On a frame start when not IDLE, the start SHALL be dropped, overrun SHALL be set, and the current computation SHALL continue unaffected.
REQ-016 FSM states: IDLE, SUM, MEAN, DEV, MAP; transitions IDLE->SUM (start), SUM->MEAN (after 16 cycles), MEAN->DEV (1 cycle), DEV->MAP (after 16 cycles), MAP->IDLE (1 cycle).
REQ-017 SUM: a 22-bit accumulator SHALL add one buffered sample per cycle, index 0..15.
REQ-018 MEAN: mean SHALL be set to sum[21:4] (truncating), 18 bits.
REQ-019 DEV: a 22-bit accumulator SHALL add |buf[i] - mean| per cycle, i = 0..15, computed without overflow.
REQ-020 MAP: avg = devsum[21:4]; level_next = 15 if avg[17:16] != 0, else avg[15:12].
REQ-021 Peak update in MAP: if level_next >= peak, then peak <= level_next and the decay counter is cleared.
REQ-022 Otherwise the decay counter SHALL increment; on reaching DECAY_FRAMES, peak decrements by 1 (never below level_next) and the counter clears.
REQ-023 level, peak and level_valid SHALL be registered on the edge ending MAP, so level_valid is high for exactly one cycle, 35 cycles after snapshot edge T.
REQ-024 level and peak SHALL hold between updates; the tick counter SHALL keep running in all FSM states.
REQ-025 A tick and MAP completion in the same cycle SHALL count as not IDLE: the start is dropped and overrun is set.

Reset
REQ-026 Reset assertion SHALL immediately force the following to 0: level, peak, level_valid, busy, overrun, accumulators, counters, sync flops, and buffer; the FSM SHALL go to IDLE.
REQ-027 Reset mid-frame SHALL abort the computation with no level_valid; the first frame start after release SHALL be processed normally.

Verification
REQ-028 All samples 0x10000 -> level_valid at T+35, level 0, peak 0.
REQ-029 Samples alternating 0x10000/0x14000 -> mean 0x12000, avg 0x2000, level 2, peak 2.
REQ-030 Samples alternating 0x00000/0x3FFC0 -> avg 0x1FFE0, level 15, peak 15; with DECAY_FRAMES=2 and constant input next, peak reads 15,14,14,13 (decrement every 2nd frame), level 0.
REQ-031 FRAME_TICKS=16, 48 clk_sampling pulses, 100-cycle period -> exactly 3 level_valid pulses, each 35 cycles after its snapshot; overrun stays 0.
REQ-032 FRAME_TICKS=1, clk_sampling period 20 cycles -> overrun set at the second tick and stays set until reset; level_valid still pulses for the accepted frames.
REQ-033 Reset asserted during DEV -> all outputs 0 immediately, no level_valid; the next frame after release gives the correct level.
